// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply controller: MIPS funct codes and FSM states.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage <-> HI/LO unit bus: op request, flush, stall/forward and HI/LO visibility.
interface muldiv_hilo_ctrl_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [5:0]       funct;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             flush;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, funct, dataA, dataB, flush,
    input  stall, busy, rd_data, hi, lo
  );

  modport slave (
    input  op_valid, funct, dataA, dataB, flush,
    output stall, busy, rd_data, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl_mul_shift_add_core.sv
// Iterative shift-add multiplier datapath: one conditional add and shift per i_step.
module mul_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product
);

  logic [2*WIDTH-1:0] r_p;
  logic [2*WIDTH-1:0] r_t;
  logic [WIDTH-1:0]   r_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p <= '0;
      r_t <= '0;
      r_y <= '0;
    end else begin
      if (i_start)
        r_p <= '0;
      else if (i_step && r_y[0])
        r_p <= r_p + r_t;

      // T is the multiplicand aligned to the current multiplier bit
      if (i_load) begin
        r_t <= {{WIDTH{1'b0}}, i_a};
        r_y <= i_b;
      end else if (i_step) begin
        r_t <= r_t << 1;
        r_y <= r_y >> 1;
      end
    end
  end

  assign o_product = r_p;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// HI/LO owner and multiplier sequencer for the MIPS EX stage.
// Define SIGNED_MULT_EN to execute MULT as signed; otherwise MULT is ignored.
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_hilo_ctrl_if.slave bus
);

  state_t r_state, w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic [WIDTH-1:0]   r_op_a, r_op_b;
  logic [WIDTH-1:0]   w_core_a, w_core_b;
  logic [2*WIDTH-1:0] w_product, w_result;
  logic w_fn_mfhi, w_fn_mflo, w_fn_mthi, w_fn_mtlo, w_fn_multu, w_fn_mult;
  logic w_hilo_op, w_accept;
  logic w_core_start, w_core_load, w_core_step;

  assign w_fn_mfhi  = (bus.funct == FN_MFHI);
  assign w_fn_mflo  = (bus.funct == FN_MFLO);
  assign w_fn_mthi  = (bus.funct == FN_MTHI);
  assign w_fn_mtlo  = (bus.funct == FN_MTLO);
  assign w_fn_multu = (bus.funct == FN_MULTU);

`ifdef SIGNED_MULT_EN
  logic r_op_signed, r_neg;

  assign w_fn_mult = (bus.funct == FN_MULT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_signed <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      if (w_accept)
        r_op_signed <= w_fn_mult;
      if (r_state == S_LOAD)
        r_neg <= r_op_signed & (r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1]);
    end
  end

  assign w_core_a = (r_op_signed && r_op_a[WIDTH-1]) ? -r_op_a : r_op_a;
  assign w_core_b = (r_op_signed && r_op_b[WIDTH-1]) ? -r_op_b : r_op_b;
  assign w_result = r_neg ? -w_product : w_product;
`else
  assign w_fn_mult = 1'b0;
  assign w_core_a  = r_op_a;
  assign w_core_b  = r_op_b;
  assign w_result  = w_product;
`endif

  assign w_hilo_op = bus.op_valid & (w_fn_mfhi | w_fn_mflo | w_fn_mthi | w_fn_mtlo |
                                     w_fn_multu | w_fn_mult);
  assign w_accept  = (r_state == S_IDLE) & bus.op_valid & (w_fn_multu | w_fn_mult) & ~bus.flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_core_start = 1'b0;
    w_core_load  = 1'b0;
    w_core_step  = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_LOAD;
      S_LOAD: begin
        w_core_start = 1'b1;
        w_core_load  = 1'b1;
        w_state_next = S_RUN;
      end
      S_RUN: begin
        w_core_step = 1'b1;
        if (r_count == CNT_W'(WIDTH - 1)) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (bus.flush && r_state != S_IDLE)
      w_state_next = S_IDLE;
  end

  // Operands are captured at accept because the pipeline moves on immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_count <= '0;
    end else begin
      if (w_accept) begin
        r_op_a <= bus.dataA;
        r_op_b <= bus.dataB;
      end
      if (r_state == S_LOAD)
        r_count <= '0;
      else if (r_state == S_RUN)
        r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == S_DONE && !bus.flush) begin
      r_hi <= w_result[2*WIDTH-1:WIDTH];
      r_lo <= w_result[WIDTH-1:0];
    end else if (r_state == S_IDLE && bus.op_valid && !bus.flush) begin
      if (w_fn_mthi) r_hi <= bus.dataA;
      if (w_fn_mtlo) r_lo <= bus.dataA;
    end
  end

  mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_core_start),
    .i_load    (w_core_load),
    .i_step    (w_core_step),
    .i_a       (w_core_a),
    .i_b       (w_core_b),
    .o_product (w_product)
  );

  assign bus.stall   = w_hilo_op & (r_state != S_IDLE);
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.rd_data = (bus.op_valid && w_fn_mfhi) ? r_hi :
                       (bus.op_valid && w_fn_mflo) ? r_lo : '0;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl with a scoreboard of expected {hi,lo} commits.
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  muldiv_hilo_ctrl_if #(.WIDTH(W)) bus();

  muldiv_hilo_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_commit(input string tag);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=commit expected=empty_scoreboard_entry", tag);
    end else begin
      logic [2*W-1:0] exp;
      exp = sb_q.pop_front();
      check(tag, {bus.hi, bus.lo}, exp);
    end
  endtask

  task automatic bus_idle();
    bus.op_valid = 1'b0;
    bus.funct    = 6'd0;
    bus.dataA    = '0;
    bus.dataB    = '0;
    bus.flush    = 1'b0;
  endtask

  // Drives a multiply for one cycle from an idle unit; returns just after the accept edge
  task automatic issue_mul(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.funct    = f;
    bus.dataA    = a;
    bus.dataB    = b;
    $display("txn mul funct=%b a=%h b=%h", f, a, b);
    @(negedge clk);
    check("issue_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic mt(input logic [5:0] f, input logic [W-1:0] v);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.funct    = f;
    bus.dataA    = v;
    $display("txn move-to funct=%b val=%h", f, v);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    @(negedge clk);
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_stall(output int n);
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  {63'd0, bus.busy},  64'd0);
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    check("rst_hilo",  {bus.hi, bus.lo},   64'd0);
    check("rst_rd",    {32'd0, bus.rd_data}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Small product and busy window length
    issue_mul(FN_MULTU, 32'd3, 32'd5);
    sb_q.push_back(64'd15);
    wait_busy(n);
    check("multu_3x5_busy", 64'(n), 64'(W + 2));
    check_commit("multu_3x5");

    // Full-range unsigned product
    issue_mul(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    sb_q.push_back(64'hFFFF_FFFE_0000_0001);
    wait_busy(n);
    check_commit("multu_max");

    // MFLO immediately behind a multiply stalls until the commit is visible
    issue_mul(FN_MULTU, 32'd7, 32'd6);
    sb_q.push_back(64'd42);
    bus.op_valid = 1'b1;
    bus.funct    = FN_MFLO;
    $display("txn mflo behind multu");
    wait_stall(n);
    check("mflo_stall_cycles", 64'(n), 64'(W + 2));
    check("mflo_rd", {32'd0, bus.rd_data}, 64'd42);
    check_commit("multu_7x6");
    @(posedge clk); #1;
    bus.op_valid = 1'b0;

    // MTHI held behind a multiply writes after the commit
    issue_mul(FN_MULTU, 32'd2, 32'd2);
    sb_q.push_back(64'd4);
    bus.op_valid = 1'b1;
    bus.funct    = FN_MTHI;
    bus.dataA    = 32'h1234;
    $display("txn mthi behind multu");
    wait_stall(n);
    check("mthi_stall_cycles", 64'(n), 64'(W + 2));
    check("mthi_hi_before", {32'd0, bus.hi}, 64'd0);
    check_commit("multu_2x2");
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    @(negedge clk);
    check("mthi_hi_after", {32'd0, bus.hi}, 64'h1234);
    check("mthi_lo_after", {32'd0, bus.lo}, 64'd4);

    // MFHI forward from idle
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.funct    = FN_MFHI;
    $display("txn mfhi");
    @(negedge clk);
    check("mfhi_stall", {63'd0, bus.stall}, 64'd0);
    check("mfhi_rd", {32'd0, bus.rd_data}, 64'h1234);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;

    // Flush in RUN at count 10 keeps prior HI/LO
    mt(FN_MTHI, 32'hA);
    mt(FN_MTLO, 32'hB);
    issue_mul(FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    $display("txn flush during run");
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {63'd0, bus.busy}, 64'd0);
    check("flush_hilo", {bus.hi, bus.lo}, {32'hA, 32'hB});
    repeat (W + 5) @(posedge clk);
    @(negedge clk);
    check("flush_hilo_late", {bus.hi, bus.lo}, {32'hA, 32'hB});

    // Asynchronous reset mid-multiply
    mt(FN_MTHI, 32'h55);
    issue_mul(FN_MULTU, 32'd100, 32'd200);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("txn reset during run");
    #1;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Flush on the accept cycle suppresses the accept
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.funct    = FN_MULTU;
    bus.dataA    = 32'd3;
    bus.dataB    = 32'd3;
    bus.flush    = 1'b1;
    $display("txn multu with flush");
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("flush_accept_busy", {63'd0, bus.busy}, 64'd0);

    // Signed MULT (or ignored MULT)
`ifdef SIGNED_MULT_EN
    issue_mul(FN_MULT, 32'hFFFF_FFFD, 32'd5);
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    wait_busy(n);
    check("mult_busy", 64'(n), 64'(W + 2));
    check_commit("mult_m3x5");
`else
    mt(FN_MTHI, 32'h77);
    mt(FN_MTLO, 32'h88);
    @(posedge clk); #1;
    bus.op_valid = 1'b1;
    bus.funct    = FN_MULT;
    bus.dataA    = 32'hFFFF_FFFD;
    bus.dataB    = 32'd5;
    $display("txn mult ignored");
    @(negedge clk);
    check("mult_off_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("mult_off_busy", {63'd0, bus.busy}, 64'd0);
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    check("mult_off_hilo", {bus.hi, bus.lo}, {32'h77, 32'h88});
`endif

    // Back-to-back MULTU: second waits for idle, then is accepted
    issue_mul(FN_MULTU, 32'd9, 32'd9);
    sb_q.push_back(64'd81);
    bus.op_valid = 1'b1;
    bus.funct    = FN_MULTU;
    bus.dataA    = 32'd10;
    bus.dataB    = 32'd10;
    $display("txn multu back-to-back");
    wait_stall(n);
    check("b2b_stall_cycles", 64'(n), 64'(W + 2));
    check_commit("b2b_first");
    sb_q.push_back(64'd100);
    @(posedge clk); #1;
    bus_idle();
    wait_busy(n);
    check("b2b_busy", 64'(n), 64'(W + 2));
    check_commit("b2b_second");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
